// File: rtl/chaos_sbox_gen_if.sv
// chaos_sbox_gen_if: request/stream bundle between an S-box consumer and chaos_sbox_gen
interface chaos_sbox_gen_if #(
  parameter int W = 32,
  parameter int SBOX_WIDTH = 8
);
  logic                  start;
  logic [W-1:0]          seed;
  logic                  busy;
  logic                  done;
  logic [SBOX_WIDTH-1:0] sbox_out;
  logic                  sbox_valid;
  modport master (output start, seed, input busy, done, sbox_out, sbox_valid);
  modport slave  (input start, seed, output busy, done, sbox_out, sbox_valid);
endinterface

// File: rtl/chaos_sbox_gen.sv
// chaos_sbox_gen: logistic-map driven generator of a 256-entry byte permutation S-box
module chaos_sbox_gen #(
  parameter int W = 32,
  parameter int MAX_TRIES = 16,
  parameter int SBOX_WIDTH = 8
) (
  input logic             clk,
  input logic             reset_n,
  chaos_sbox_gen_if.slave bus
);
  localparam int TW = MAX_TRIES > 1 ? $clog2(MAX_TRIES) : 1;
  localparam logic [W-1:0] C = W'(32'h9E3779B9);
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ITER, SCAN, DONE} state_t;
  state_t                state_q;
  logic [W-1:0]          x_q;
  logic [255:0]          used_q;
  logic [8:0]            count_q;
  logic [TW-1:0]         tries_q;
  logic [7:0]            ptr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  valid_q;
  logic [SBOX_WIDTH-1:0] out_q;
  logic [W:0]            comp;
  logic [2*W-1:0]        prod;
  logic [W:0]            n_full;
  logic [W-1:0]          x_d;
  logic [W-1:0]          seed_d;
  logic [7:0]            cand;
  logic [7:0]            emit_d;
  logic                  hit;
  // x*(2^W-x) scaled by 4/2^W; n_full only reaches 2^W at x = 2^(W-1)
  always_comb begin
    comp = {1'b1, {W{1'b0}}} - {1'b0, x_q};
    prod = {{W{1'b0}}, x_q} * {{(W-1){1'b0}}, comp};
    n_full = (W+1)'(prod >> (W-2));
    x_d = n_full[W] ? '1 : (n_full[W-1:0] == '0 ? C : n_full[W-1:0]);
    cand = x_d[W-1:W-8] ^ x_d[7:0];
    seed_d = (bus.seed == '0 || bus.seed == HALF) ? C : bus.seed;
    emit_d = state_q == SCAN ? ptr_q : cand;
    hit = !used_q[emit_d];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      used_q  <= '0;
      count_q <= '0;
      tries_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.start && !done_q) begin
          x_q     <= seed_d;
          used_q  <= '0;
          count_q <= '0;
          tries_q <= '0;
          busy_q  <= 1'b1;
          state_q <= ITER;
        end
        ITER, SCAN: begin
          if (state_q == ITER) x_q <= x_d;
          if (hit) begin
            used_q[emit_d] <= 1'b1;
            count_q        <= count_q + 9'd1;
            tries_q        <= '0;
            out_q          <= SBOX_WIDTH'(emit_d);
            valid_q        <= 1'b1;
            state_q        <= count_q == 9'd255 ? DONE : ITER;
          end else if (state_q == SCAN) begin
            ptr_q <= ptr_q + 8'd1;
          end else if (tries_q < TW'(MAX_TRIES - 1)) begin
            tries_q <= tries_q + 1'b1;
          end else begin
            // perturb the map so a fixed point is not re-entered after the scan
            x_q     <= x_d + C;
            ptr_q   <= cand + 8'd1;
            state_q <= SCAN;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sbox_valid = valid_q;
  assign bus.sbox_out   = out_q;
endmodule

// File: tb/tb_chaos_sbox_gen.sv
// tb_chaos_sbox_gen: randomized and directed checks of chaos_sbox_gen against a cycle-counting reference model
module tb_chaos_sbox_gen;
  localparam logic [31:0] C = 32'h9E3779B9;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  chaos_sbox_gen_if #(.W(32), .SBOX_WIDTH(8)) bus ();
  chaos_sbox_gen #(.W(32), .MAX_TRIES(16), .SBOX_WIDTH(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_b [256];
  int         exp_t [256];
  int         exp_done;
  logic [7:0] got_b [256];
  int         got_t [256];
  logic [7:0] ref_b [256];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // expected stream and per-entry edge number (start edge = 0)
  task automatic model(input logic [31:0] seed);
    bit seen [256];
    logic [63:0] x, n;
    logic [7:0] c, ptr;
    int cnt = 0, tries = 0, e = 0;
    bit found;
    x = (seed == 0 || seed == 32'h80000000) ? 64'(C) : 64'(seed);
    while (cnt < 256) begin
      e++;
      n = (x * ((64'd1 << 32) - x)) >> 30;
      if (n == (64'd1 << 32)) n = n - 1;
      if (n == 0) n = 64'(C);
      x = n;
      c = n[31:24] ^ n[7:0];
      if (!seen[c]) begin
        seen[c] = 1; exp_b[cnt] = c; exp_t[cnt] = e; cnt++; tries = 0;
      end else if (tries < 15) begin
        tries++;
      end else begin
        x = (n + 64'(C)) & 64'hFFFF_FFFF;
        ptr = c + 8'd1;
        do begin
          e++;
          found = !seen[ptr];
          if (!found) ptr = ptr + 8'd1;
        end while (!found);
        seen[ptr] = 1; exp_b[cnt] = ptr; exp_t[cnt] = e; cnt++; tries = 0;
      end
    end
    exp_done = e + 1;
  endtask
  task automatic run(input logic [31:0] seed, input int mid_at, input int rst_at);
    int k = 0, cyc = 0, d = 0;
    bit fin = 0;
    bit hist [256];
    model(seed);
    @(negedge clk);
    bus.seed = seed;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("valid_after_start", bus.sbox_valid, 0);
    while (!fin && cyc < exp_done + 5) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == mid_at);
      if (cyc == mid_at) bus.seed = ~seed;
      if (bus.sbox_valid) begin
        if (k < 256) begin
          chk($sformatf("byte[%0d]", k), bus.sbox_out, exp_b[k]);
          chk($sformatf("time[%0d]", k), cyc, exp_t[k]);
          got_b[k] = bus.sbox_out;
          got_t[k] = cyc;
          hist[bus.sbox_out] = 1;
        end else chk("extra_pulse", k, 255);
        k++;
        if (k == rst_at) begin
          reset_n = 1'b0;
          #1;
          chk("rst_busy", bus.busy, 0);
          chk("rst_done", bus.done, 0);
          chk("rst_valid", bus.sbox_valid, 0);
          chk("rst_out", bus.sbox_out, 0);
          @(negedge clk);
          reset_n = 1'b1;
          repeat (2) @(negedge clk);
          return;
        end
      end
      if (bus.done) begin
        chk("done_time", cyc, exp_done);
        chk("pulse_count", k, 256);
        chk("busy_in_done", bus.busy, 0);
        fin = 1;
      end else chk("busy_mid", bus.busy, 1);
    end
    bus.start = 1'b0;
    chk("done_seen", fin, 1);
    foreach (hist[i]) if (hist[i]) d++;
    chk("distinct", d, 256);
    @(negedge clk);
    chk("done_width", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic same_as_ref(input string tag);
    int diff = 0;
    foreach (got_b[i]) if (got_b[i] !== ref_b[i]) diff++;
    chk(tag, diff, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.seed = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_valid", bus.sbox_valid, 0);
    chk("reset_out", bus.sbox_out, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run(32'h40000000, 0, 0);
    chk("scan_first_byte", got_b[0], 8'hC0);
    chk("scan_first_time", got_t[0], 1);
    chk("scan_second_byte", got_b[1], 8'hC1);
    chk("scan_second_time", got_t[1], 18);
    run(32'h12345678, 0, 0);
    run(32'hDEADBEEF, 60, 0);
    run(32'h00000001, 0, 0);
    run(32'h00000000, 0, 0);
    ref_b = got_b;
    run(C, 0, 0);
    same_as_ref("seed0_vs_C");
    run(32'h80000000, 0, 0);
    same_as_ref("seed_half_vs_C");
    run(32'h12345678, 0, 100);
    run(32'h12345678, 0, 0);
    run($urandom, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/chaos_sbox_gen.md
# chaos_sbox_gen

Generates the 256-entry byte S-box consumed by `feistel_encrypt`, driving its `sbox_out`/`sbox_valid` load port directly. The block iterates a fixed-point logistic map from a seed and derives a candidate byte each step. A 256-bit used-bitmap rejects duplicates, and a bounded-retry linear scan guarantees termination. The output is always a permutation of 0..255, streamed in table-index order.

## Interface
- `W`, 32: logistic-map state width in bits. Must be at least 16.
- `MAX_TRIES`, 16: consecutive rejections allowed before falling back to the scan.
- `SBOX_WIDTH`, 8: output byte width. Only 8 is supported.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request. Ignored while `busy` or `done`.
- `seed` input W: initial map state, sampled on the `start` edge.
- `busy` output 1: generation in progress.
- `done` output 1: one-cycle pulse after the 256th entry.
- `sbox_out` output SBOX_WIDTH: S-box entry. Valid only with `sbox_valid`.
- `sbox_valid` output 1: the consumer stores entry i on the i-th pulse (i = 0..255). Pulses may be non-contiguous.

## Operation
- State registers: `x` (W bits), `used` (256 bits), `count` (9 bits), `tries` (log2 MAX_TRIES bits), `ptr` (8 bits).
- FSM states:
  - IDLE: waits for `start`.
  - ITER: one map step per cycle.
  - SCAN: linear search for a free byte.
  - DONE: pulses `done`.
- Seed sanitising, on the `start` edge:
  - seed 0 or 2^(W-1) is replaced by the constant C = 0x9E3779B9 (truncated to W bits).
  - `used` is cleared; `count` and `tries` are cleared.
  - Transition IDLE→ITER.
- Map step (ITER):
  - p = x·(2^W − x), a 2W-bit product. The second operand is W+1 bits wide.
  - n = (4p) >> W, i.e. p[2W-1:W-2].
  - If n = 2^W, saturate n to 2^W−1.
  - If n = 0, set n = C.
  - `x` ← n every ITER cycle.
- Candidate byte: cand = n[W-1:W-8] XOR n[7:0].
- ITER, candidate accepted (`used[cand]` = 0):
  - `sbox_out` ← cand, `sbox_valid` ← 1.
  - Set `used[cand]`, increment `count`, clear `tries`.
- ITER, candidate rejected:
  - If `tries` < MAX_TRIES−1, increment `tries`.
  - Otherwise go to SCAN with `ptr` ← cand+1 (mod 256) and `x` ← (n + C) mod 2^W. This perturbation escapes fixed points.
- SCAN, each cycle:
  - If `used[ptr]` = 0: emit `ptr`, mark it used, increment `count`, clear `tries`, return to ITER.
  - Otherwise `ptr` ← `ptr`+1 (mod 256).
  - SCAN cannot loop, because it is entered only while `count` < 256.
- Completion: the emission that makes `count` = 256 moves the FSM to DONE instead of ITER or SCAN. DONE lasts one cycle, then returns to IDLE.
- Mid-operation reset (`reset_n` low): all state and outputs clear immediately. The partial table in the consumer is invalid and must be reloaded by a new `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `sbox_valid`=0, `sbox_out`=0, FSM=IDLE. Internal registers also clear: `x`=0, `used`=0, `count`=0, `tries`=0, `ptr`=0.
- All outputs are registered.
- `start` sampled at edge E:
  - `busy` is high from E+1.
  - The earliest `sbox_valid` is after edge E+1.
- `sbox_valid` is high for exactly the cycle following each accepting edge. `sbox_out` holds its value otherwise.
- `busy` drops and `done` rises on the edge after the 256th `sbox_valid` cycle begins. `done` is high for exactly one cycle and `busy` stays 0 during it.
- Acceptance of a new `start` resumes on the cycle after `done`.
- Worst-case gap between consecutive `sbox_valid` pulses: MAX_TRIES + 256 cycles.

## Test plan
- **Scan fallback:** seed 0x40000000, `start` at edge 0.
  - `sbox_out`=0xC0 after edge 1 (n=0xC0000000).
  - Edges 2..17 reject (fixed point 0.75); SCAN is entered at edge 17 with `x`=0x5E3779B9.
  - `sbox_out`=0xC1 after edge 18.
- **Permutation property:** seeds 0x12345678, 0xDEADBEEF, 0x00000001.
  - Exactly 256 `sbox_valid` pulses.
  - Every value 0..255 appears exactly once.
  - `done` pulses once, one cycle after the last pulse.
- **Seed sanitising:** seed 0 and seed 0x9E3779B9 produce identical 256-byte streams and identical cycle timing. Seed 0x80000000 produces the same stream as well.
- **Start while busy:** a `start` pulse with a different seed mid-run has no effect on the stream or on `done` timing.
- **Reset mid-run:** `reset_n` low after the 100th pulse.
  - All outputs are 0 on the next sample.
  - After release, a `start` with the same seed reproduces the full original stream.
- **Integration with `feistel_encrypt`:** stream into `feistel_encrypt` with keys K0..K4 = 0x00..0F through 0x40..4F, then apply two plaintext blocks. The ciphertext must match the golden model using this generator's S-box.
